// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: redirect kinds, default vectors
// and small helpers used by pc_unit and pc_ras.
package pc_pkg;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JUMP   = 2'd1,
    KIND_CALL   = 2'd2,
    KIND_RET    = 2'd3
  } redirect_kind_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_4180;
  localparam int          DEFAULT_WIDTH        = 32;
  localparam int          DEFAULT_RAS_DEPTH    = 4;

  // Instruction fetch addresses must be word aligned.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: DEPTH entries of WIDTH bits, saturating count.
// A push on a full stack overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_RAS_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ptr_q is the next free slot; the top of stack sits just below it.
  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (count_q != CNT_FULL) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_data = mem_q[ptr_q - PTR_W'(1)];
  assign empty    = (count_q == '0);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, exception PC and next-PC selection.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_kind,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic [WIDTH-1:0] redirect_link,
  input  logic             exc_valid,
  input  logic             eret_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic             ras_miss
);

  if (WIDTH < 8) begin : g_bad_width
    $error("pc_unit: WIDTH must be at least 8");
  end
  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_unit: RAS_DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             misalign_q, misalign_d;
  logic             ras_miss_q, ras_miss_d;
  logic             redirect_ok;

`ifdef PC_RAS_EN
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (redirect_link),
    .top_data  (ras_top),
    .empty     (ras_empty)
  );
`else
  // Without the stack the link address has no consumer.
  logic unused_link;
  assign unused_link = ^redirect_link;
`endif

  assign pc_plus4    = pc_q + WIDTH'(4);
  assign redirect_ok = is_word_aligned(redirect_target[1:0]);

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    ras_miss_d = 1'b0;
`ifdef PC_RAS_EN
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
`endif
    if (exc_valid) begin
      epc_d = pc_q;
      pc_d  = EXC_VECTOR;
    end else if (eret_valid) begin
      pc_d = epc_q;
    end else if (!en) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      if (!redirect_ok) begin
        misalign_d = 1'b1;
      end else begin
        case (redirect_kind)
          KIND_CALL: begin
            pc_d = redirect_target;
`ifdef PC_RAS_EN
            ras_push = 1'b1;
`endif
          end
          KIND_RET: begin
`ifdef PC_RAS_EN
            if (ras_empty) begin
              pc_d       = redirect_target;
              ras_miss_d = 1'b1;
            end else begin
              pc_d    = ras_top;
              ras_pop = 1'b1;
            end
`else
            pc_d = redirect_target;
`endif
          end
          default: pc_d = redirect_target;
        endcase
      end
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= RESET_VECTOR;
      misalign_q <= 1'b0;
      ras_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
      ras_miss_q <= ras_miss_d;
    end
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;
  assign ras_miss = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_kind = 2'd0;
  logic [31:0] redirect_target = '0;
  logic [31:0] redirect_link = '0;
  logic        exc_valid = 1'b0;
  logic        eret_valid = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        misalign, ras_miss;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] K_BR = 2'd0, K_JMP = 2'd1, K_CALL = 2'd2, K_RET = 2'd3;

`ifdef PC_RAS_EN
  localparam logic RAS_ON = 1'b1;
`else
  localparam logic RAS_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        miss;
  } exp_t;

  exp_t sb[$];

  pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .redirect_link   (redirect_link),
    .exc_valid       (exc_valid),
    .eret_valid      (eret_valid),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .epc             (epc),
    .misalign        (misalign),
    .ras_miss        (ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every edge that has a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".pc"}, pc, e.pc);
        chk({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        chk({e.name, ".epc"}, epc, e.epc);
        chk({e.name, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
        chk({e.name, ".ras_miss"}, {31'd0, ras_miss}, {31'd0, e.miss});
      end
    end
  end

  // One cycle of stimulus plus the state expected right after the next edge.
  task automatic step(input logic r, input logic e, input logic rv, input logic [1:0] k,
                      input logic [31:0] tgt, input logic [31:0] lnk,
                      input logic ex, input logic er, input string nm,
                      input logic [31:0] x_pc, input logic [31:0] x_epc,
                      input logic x_mis, input logic x_miss);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; redirect_valid = rv; redirect_kind = k;
    redirect_target = tgt; redirect_link = lnk; exc_valid = ex; eret_valid = er;
    x.name = nm; x.pc = x_pc; x.epc = x_epc; x.mis = x_mis; x.miss = x_miss;
    sb.push_back(x);
  endtask

  initial begin
    //    rst en rv kind    target        link    exc eret name          pc            epc           mis miss
    step(1, 0, 0, K_JMP,  32'h0,        32'h0,  0, 0, "reset",      32'h3000,     32'h3000,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "seq1",       32'h3004,     32'h3000,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "seq2",       32'h3008,     32'h3000,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "seq3",       32'h300C,     32'h3000,     0, 0);
    step(0, 0, 1, K_JMP,  32'h3100,     32'h0,  0, 0, "stall_drop", 32'h300C,     32'h3000,     0, 0);
    step(0, 1, 1, K_JMP,  32'h3100,     32'h0,  0, 0, "jump",       32'h3100,     32'h3000,     0, 0);
    step(0, 1, 1, K_JMP,  32'h3010,     32'h0,  0, 0, "jump2",      32'h3010,     32'h3000,     0, 0);
    step(0, 1, 1, K_JMP,  32'h3200,     32'h0,  1, 0, "exc_jmp",    32'h4180,     32'h3010,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "exc_seq",    32'h4184,     32'h3010,     0, 0);
    step(0, 0, 0, K_JMP,  32'h0,        32'h0,  0, 1, "eret_en0",   32'h3010,     32'h3010,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "seq4",       32'h3014,     32'h3010,     0, 0);
    step(0, 1, 1, K_JMP,  32'h3102,     32'h0,  0, 0, "misalign",   32'h3014,     32'h3010,     1, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "mis_clear",  32'h3018,     32'h3010,     0, 0);
    step(0, 0, 0, K_JMP,  32'h0,        32'h0,  1, 0, "exc_en0",    32'h4180,     32'h3018,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "seq5",       32'h4184,     32'h3018,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  1, 1, "exc_eret",   32'h4180,     32'h4184,     0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 1, "eret",       32'h4184,     32'h4184,     0, 0);
    step(0, 1, 1, K_JMP,  32'hFFFF_FFFC, 32'h0, 0, 0, "to_top",     32'hFFFF_FFFC, 32'h4184,    0, 0);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "wrap",       32'h0,        32'h4184,     0, 0);
    step(0, 1, 1, K_BR,   32'h20,       32'h0,  0, 0, "branch",     32'h20,       32'h4184,     0, 0);
    step(0, 1, 1, K_CALL, 32'h100,      32'h24, 0, 0, "call",       32'h100,      32'h4184,     0, 0);
    step(0, 1, 1, K_RET,  32'h200,      32'h0,  0, 0, "ret",        RAS_ON ? 32'h24 : 32'h200, 32'h4184, 0, 0);
    step(0, 1, 1, K_CALL, 32'h300,      32'h104, 0, 0, "call_a",    32'h300,      32'h4184,     0, 0);
    step(1, 1, 1, K_CALL, 32'h400,      32'h304, 1, 0, "rst_call",  32'h3000,     32'h3000,     0, 0);
    step(0, 1, 1, K_RET,  32'hFF0,      32'h0,  0, 0, "ret_empty",  32'hFF0,      32'h3000,     0, RAS_ON);
    step(0, 1, 0, K_JMP,  32'h0,        32'h0,  0, 0, "miss_clear", 32'hFF4,      32'h3000,     0, 0);
`ifdef PC_RAS_EN
    for (int i = 0; i < 5; i++)
      step(0, 1, 1, K_CALL, 32'h1000 + 32'h100 * i, 32'h10 * (i + 1), 0, 0, $sformatf("call%0d", i),
           32'h1000 + 32'h100 * i, 32'h3000, 0, 0);
    step(0, 1, 1, K_RET, 32'hFF0, 32'h0, 0, 0, "pop0", 32'h50,  32'h3000, 0, 0);
    step(0, 1, 1, K_RET, 32'hFF0, 32'h0, 0, 0, "pop1", 32'h40,  32'h3000, 0, 0);
    step(0, 1, 1, K_RET, 32'hFF0, 32'h0, 0, 0, "pop2", 32'h30,  32'h3000, 0, 0);
    step(0, 1, 1, K_RET, 32'hFF0, 32'h0, 0, 0, "pop3", 32'h20,  32'h3000, 0, 0);
    step(0, 1, 1, K_RET, 32'hFF0, 32'h0, 0, 0, "pop4", 32'hFF0, 32'h3000, 0, 1);
`endif
    @(negedge clk);
    redirect_valid = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0; en = 1'b0;
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
